// File: rtl/ibex_regfile_cache_if.sv
// Backing-store (L2 register file) port of the register-file cache.
// The master side is the cache; the slave side is the backing store.
interface ibex_regfile_cache_if #(
  parameter int DataWidth = 32
);
  logic                 l2_re_o;
  logic [4:0]           l2_raddr_o;
  logic [DataWidth-1:0] l2_rdata_i;
  logic                 l2_we_o;
  logic [4:0]           l2_waddr_o;
  logic [DataWidth-1:0] l2_wdata_o;

  modport master (
    output l2_re_o, l2_raddr_o, l2_we_o, l2_waddr_o, l2_wdata_o,
    input  l2_rdata_i
  );
  modport slave (
    input  l2_re_o, l2_raddr_o, l2_we_o, l2_waddr_o, l2_wdata_o,
    output l2_rdata_i
  );
endinterface

// File: rtl/ibex_regfile_cache.sv
// Small fully-associative, write-through cache in front of the register file.
// Read misses stall ID while one or two entries are filled from the backing store.
module ibex_regfile_cache #(
  parameter int DataWidth    = 32,
  parameter int CacheEntries = 4,
  parameter bit RV32E        = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rd_req_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 we_a_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic [31:0]          miss_cnt_o,
  ibex_regfile_cache_if.master l2
);
  localparam int         IdxW     = (CacheEntries > 1) ? $clog2(CacheEntries) : 1;
  localparam logic [4:0] AddrMask = RV32E ? 5'h0f : 5'h1f;

  typedef enum logic [1:0] {IDLE, FILL_A, FILL_B} state_e;

  state_e                                  r_state;
  logic [CacheEntries-1:0]                 r_valid;
  logic [CacheEntries-1:0][4:0]            r_tag;
  logic [CacheEntries-1:0][DataWidth-1:0]  r_data;
  logic [IdxW-1:0]                         r_ptr;
  logic [4:0]                              r_addr_a, r_addr_b;
  logic                                    r_b_miss;
  logic                                    r_ovr_vld;
  logic [DataWidth-1:0]                    r_ovr_data;
  logic [31:0]                             r_miss_cnt;

  logic [4:0]              w_ra, w_rb, w_wa;
  logic                    w_wr_en;
  logic                    w_hit_a, w_hit_b, w_miss;
  logic [DataWidth-1:0]    w_rdata_a, w_rdata_b;
  logic [CacheEntries-1:0] w_whit;
  logic [IdxW-1:0]         w_vic;
  logic                    w_vic_valid;
  logic                    w_req;
  logic [4:0]              w_req_addr;
  logic                    w_fill;
  logic [4:0]              w_fill_addr;
  logic [DataWidth-1:0]    w_fill_data;

  assign w_ra    = raddr_a_i & AddrMask;
  assign w_rb    = raddr_b_i & AddrMask;
  assign w_wa    = waddr_a_i & AddrMask;
  assign w_wr_en = we_a_i && (w_wa != 5'd0);

  // x0 is never allocated, so it can never match a tag and reads as zero.
  always_comb begin
    w_hit_a   = (w_ra == 5'd0);
    w_hit_b   = (w_rb == 5'd0);
    w_rdata_a = '0;
    w_rdata_b = '0;
    w_whit    = '0;
    for (int i = 0; i < CacheEntries; i++) begin
      if (r_valid[i] && r_tag[i] == w_ra) begin
        w_hit_a   = 1'b1;
        w_rdata_a = w_rdata_a | r_data[i];
      end
      if (r_valid[i] && r_tag[i] == w_rb) begin
        w_hit_b   = 1'b1;
        w_rdata_b = w_rdata_b | r_data[i];
      end
      w_whit[i] = w_wr_en && r_valid[i] && (r_tag[i] == w_wa);
    end
  end

  // Lowest-index free entry first; round-robin pointer only once full.
  always_comb begin
    w_vic       = r_ptr;
    w_vic_valid = 1'b1;
    for (int i = CacheEntries - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_vic       = IdxW'(i);
        w_vic_valid = 1'b0;
      end
    end
  end

  assign w_miss = (r_state == IDLE) && rd_req_i && (!w_hit_a || !w_hit_b);

  always_comb begin
    w_req      = 1'b0;
    w_req_addr = w_ra;
    case (r_state)
      IDLE: if (w_miss) begin
        w_req      = 1'b1;
        w_req_addr = !w_hit_a ? w_ra : w_rb;
      end
      FILL_A: if (r_b_miss && (r_addr_b != r_addr_a)) begin
        w_req      = 1'b1;
        w_req_addr = r_addr_b;
      end
      default: ;
    endcase
  end

  // A write to the address being fetched beats the (possibly stale) L2 data,
  // whether it lands in the request cycle (latched) or in the fill cycle.
  assign w_fill      = (r_state != IDLE);
  assign w_fill_addr = (r_state == FILL_B) ? r_addr_b : r_addr_a;
  assign w_fill_data = (w_wr_en && (w_wa == w_fill_addr)) ? wdata_a_i :
                       r_ovr_vld                          ? r_ovr_data : l2.l2_rdata_i;

  assign stall_o       = w_fill || w_miss;
  assign rdata_a_o     = w_rdata_a;
  assign rdata_b_o     = w_rdata_b;
  assign miss_cnt_o    = r_miss_cnt;
  assign l2.l2_re_o    = w_req;
  assign l2.l2_raddr_o = w_req_addr;
  assign l2.l2_we_o    = w_wr_en;
  assign l2.l2_waddr_o = w_wa;
  assign l2.l2_wdata_o = wdata_a_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_ptr      <= '0;
      r_miss_cnt <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_b_miss   <= 1'b0;
      r_ovr_vld  <= 1'b0;
      r_ovr_data <= '0;
    end else if (flush_i) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      r_ptr     <= '0;
      r_ovr_vld <= 1'b0;
    end else begin
      r_ovr_vld  <= w_req && w_wr_en && (w_wa == w_req_addr);
      r_ovr_data <= wdata_a_i;
      case (r_state)
        IDLE: if (w_miss) begin
          r_addr_a <= w_ra;
          r_addr_b <= w_rb;
          r_b_miss <= !w_hit_b;
          r_state  <= !w_hit_a ? FILL_A : FILL_B;
        end
        FILL_A:  r_state <= w_req ? FILL_B : IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_fill) begin
        r_valid[w_vic] <= 1'b1;
        if (w_vic_valid) r_ptr <= r_ptr + IdxW'(1);
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  // Payload arrays carry no reset; the valid bits alone define contents.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int i = 0; i < CacheEntries; i++) begin
        if (w_whit[i]) r_data[i] <= wdata_a_i;
      end
      if (w_fill) begin
        r_data[w_vic] <= w_fill_data;
        r_tag[w_vic]  <= w_fill_addr;
      end
    end
  end
endmodule

// File: tb/tb_ibex_regfile_cache.sv
// Bench for ibex_regfile_cache: directed vector table, hand-written corner
// sequences and a random phase scored against a transaction-level cache model.
module tb_ibex_regfile_cache;
  localparam int NE = 4;

  logic        clk, rst_n, rd_req, we, flush;
  logic [4:0]  ra, rb, wa;
  logic [31:0] wd;
  logic [31:0] rda, rdb, cnt;
  logic        stall;
  logic        mem_init;
  logic [31:0] mem [32];
  logic [31:0] rd_q;
  logic [31:0] ref_r [32];

  int total = 0;
  int bad   = 0;

  ibex_regfile_cache_if #(.DataWidth(32)) l2 ();

  ibex_regfile_cache #(.DataWidth(32), .CacheEntries(NE), .RV32E(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_req_i(rd_req),
    .raddr_a_i(ra), .raddr_b_i(rb), .rdata_a_o(rda), .rdata_b_o(rdb),
    .waddr_a_i(wa), .wdata_a_i(wd), .we_a_i(we), .flush_i(flush),
    .stall_o(stall), .miss_cnt_o(cnt), .l2(l2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing store: registered read, data one cycle after the request.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA0 + i;
    end else if (l2.l2_we_o) mem[l2.l2_waddr_o] <= l2.l2_wdata_o;
    if (l2.l2_re_o) rd_q <= mem[l2.l2_raddr_o];
  end
  assign l2.l2_rdata_i = rd_q;

  // Transaction-level model of cache occupancy.
  bit m_v [NE];
  int m_t [NE];
  int m_ptr, m_cnt;

  function automatic void m_clear();
    for (int i = 0; i < NE; i++) m_v[i] = 1'b0;
    m_ptr = 0;
  endfunction

  function automatic bit m_hit(int a);
    if (a == 0) return 1'b1;
    for (int i = 0; i < NE; i++) if (m_v[i] && m_t[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_fill(int a);
    int v = -1;
    for (int i = NE - 1; i >= 0; i--) if (!m_v[i]) v = i;
    if (v < 0) begin
      v = m_ptr;
      m_ptr = (m_ptr + 1) % NE;
    end
    m_v[v] = 1'b1;
    m_t[v] = a;
    m_cnt++;
  endfunction

  // Stall cycles until both ports hit; a fill may evict the other port's line.
  function automatic int m_read(int a, int b);
    int st = 0;
    bit ma, mb;
    for (int r = 0; r < 4; r++) begin
      ma = !m_hit(a);
      mb = !m_hit(b) && !(ma && a == b);
      if (!ma && !mb) break;
      st += 1 + int'(ma) + int'(mb);
      if (ma) m_fill(a);
      if (mb) m_fill(b);
    end
    return st;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rd_req = 1'b0; we = 1'b0; flush = 1'b0;
    ra = '0; rb = '0; wa = '0; wd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b, output int n,
                    output logic [31:0] da, output logic [31:0] db);
    @(posedge clk); #1;
    rd_req = 1'b1; ra = a; rb = b; n = 0;
    @(negedge clk);
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("stall_timeout", 32'(n), 32'd0);
    da = rda; db = rdb;
    @(posedge clk); #1 rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    chk("wr_l2_we", 32'(l2.l2_we_o), 32'(a != 5'd0));
    if (a != 5'd0) begin
      chk("wr_l2_waddr", 32'(l2.l2_waddr_o), 32'(a));
      chk("wr_l2_wdata", l2.l2_wdata_o, d);
      ref_r[a] = d;
    end
    @(posedge clk); #1 we = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  a, b;
    int          st;
    logic [31:0] da, db, cnt;
  } vec_t;
  vec_t tbl [9];

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, es, sel;
    logic [31:0] da, db, d;
    logic [4:0] a, b;

    tbl[0] = '{5'd5,  5'd0, 2, 32'hA5, 32'h00, 32'd1};
    tbl[1] = '{5'd3,  5'd7, 3, 32'hA3, 32'hA7, 32'd3};
    tbl[2] = '{5'd5,  5'd3, 0, 32'hA5, 32'hA3, 32'd3};
    tbl[3] = '{5'd9,  5'd9, 2, 32'hA9, 32'hA9, 32'd4};
    tbl[4] = '{5'd11, 5'd0, 2, 32'hAB, 32'h00, 32'd5};
    tbl[5] = '{5'd5,  5'd7, 2, 32'hA5, 32'hA7, 32'd6};
    tbl[6] = '{5'd0,  5'd3, 2, 32'h00, 32'hA3, 32'd7};
    tbl[7] = '{5'd7,  5'd9, 4, 32'hA7, 32'hA9, 32'd9};
    tbl[8] = '{5'd11, 5'd5, 4, 32'hAB, 32'hA5, 32'd11};

    for (int i = 0; i < 32; i++) ref_r[i] = (i == 0) ? 32'd0 : 32'hA0 + i;
    mem_init = 1'b1;
    rst_n = 1'b0; rd_req = 1'b0; we = 1'b0; flush = 1'b0;
    ra = '0; rb = '0; wa = '0; wd = '0;
    @(posedge clk); #1 mem_init = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_l2_re", 32'(l2.l2_re_o), 32'd0);
    chk("rst_l2_we", 32'(l2.l2_we_o), 32'd0);
    chk("rst_cnt", cnt, 32'd0);

    for (int i = 0; i < 9; i++) begin
      rd(tbl[i].a, tbl[i].b, n, da, db);
      chk($sformatf("tbl%0d_stall", i), 32'(n), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_rda", i), da, tbl[i].da);
      chk($sformatf("tbl%0d_rdb", i), db, tbl[i].db);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
    end

    // Cold double miss: L2 read order and three stall cycles.
    do_reset();
    @(posedge clk); #1 rd_req = 1'b1; ra = 5'd3; rb = 5'd7;
    @(negedge clk);
    chk("cold_s0", 32'(stall), 32'd1);
    chk("cold_re0", 32'(l2.l2_re_o), 32'd1);
    chk("cold_ad0", 32'(l2.l2_raddr_o), 32'd3);
    @(negedge clk);
    chk("cold_s1", 32'(stall), 32'd1);
    chk("cold_re1", 32'(l2.l2_re_o), 32'd1);
    chk("cold_ad1", 32'(l2.l2_raddr_o), 32'd7);
    @(negedge clk);
    chk("cold_s2", 32'(stall), 32'd1);
    chk("cold_re2", 32'(l2.l2_re_o), 32'd0);
    @(negedge clk);
    chk("cold_s3", 32'(stall), 32'd0);
    chk("cold_rda", rda, ref_r[3]);
    chk("cold_rdb", rdb, ref_r[7]);
    chk("cold_cnt", cnt, 32'd2);
    @(posedge clk); #1 rd_req = 1'b0;

    // Write lands during the fill cycle of the same register.
    @(posedge clk); #1 rd_req = 1'b1; ra = 5'd9; rb = 5'd0;
    @(negedge clk);
    chk("wfill_s0", 32'(stall), 32'd1);
    @(posedge clk); #1 we = 1'b1; wa = 5'd9; wd = 32'h1234;
    @(negedge clk);
    chk("wfill_s1", 32'(stall), 32'd1);
    chk("wfill_we", 32'(l2.l2_we_o), 32'd1);
    chk("wfill_wa", 32'(l2.l2_waddr_o), 32'd9);
    @(posedge clk); #1 we = 1'b0; ref_r[9] = 32'h1234;
    @(negedge clk);
    chk("wfill_s2", 32'(stall), 32'd0);
    chk("wfill_rda", rda, 32'h1234);
    @(posedge clk); #1 rd_req = 1'b0;
    rd(5'd9, 5'd0, n, da, db);
    chk("wfill_again_st", 32'(n), 32'd0);
    chk("wfill_again_rd", da, 32'h1234);

    // Write lands in the request cycle of the same register.
    @(posedge clk); #1 rd_req = 1'b1; ra = 5'd10; rb = 5'd0;
    we = 1'b1; wa = 5'd10; wd = 32'hBEEF;
    @(negedge clk);
    chk("wreq_re", 32'(l2.l2_re_o), 32'd1);
    @(posedge clk); #1 we = 1'b0; ref_r[10] = 32'hBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("wreq_s", 32'(stall), 32'd0);
    chk("wreq_rda", rda, 32'hBEEF);
    @(posedge clk); #1 rd_req = 1'b0;

    // Hit, no-bypass write, flush, then x0 write.
    rd(5'd4, 5'd0, n, da, db);
    chk("x4_miss", 32'(n), 32'd2);
    @(posedge clk); #1 rd_req = 1'b1; ra = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h4444;
    @(negedge clk);
    chk("x4_hit", 32'(stall), 32'd0);
    chk("x4_old", rda, ref_r[4]);
    @(posedge clk); #1 we = 1'b0; ref_r[4] = 32'h4444;
    @(negedge clk);
    chk("x4_new", rda, 32'h4444);
    @(posedge clk); #1 rd_req = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    rd(5'd4, 5'd0, n, da, db);
    chk("flush_st", 32'(n), 32'd2);
    chk("flush_rd", da, 32'h4444);
    do_write(5'd0, 32'hDEAD);

    // Flush while a fill is in flight.
    c0 = int'(cnt);
    @(posedge clk); #1 rd_req = 1'b1; ra = 5'd12; rb = 5'd0;
    @(negedge clk);
    @(posedge clk); #1 rd_req = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("fabort_st", 32'(stall), 32'd0);
    chk("fabort_cnt", cnt, 32'(c0));
    rd(5'd12, 5'd0, n, da, db);
    chk("fabort_refill", 32'(n), 32'd2);

    // Reset while a fill is in flight.
    @(posedge clk); #1 rd_req = 1'b1; ra = 5'd13; rb = 5'd0;
    @(negedge clk);
    @(posedge clk); #1 rd_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rabort_cnt", cnt, 32'd0);
    chk("rabort_st", 32'(stall), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    rd(5'd12, 5'd0, n, da, db);
    chk("rabort_x12", 32'(n), 32'd2);
    rd(5'd13, 5'd0, n, da, db);
    chk("rabort_x13", 32'(n), 32'd2);
    chk("rabort_x13d", da, ref_r[13]);

    // Random traffic scored against the model.
    do_reset();
    m_clear();
    m_cnt = 0;
    for (int k = 0; k < 250; k++) begin
      sel = $urandom_range(0, 9);
      a = 5'($urandom_range(0, 9));
      b = 5'($urandom_range(0, 9));
      if (sel <= 5) begin
        es = m_read(int'(a), int'(b));
        rd(a, b, n, da, db);
        chk("rnd_stall", 32'(n), 32'(es));
        chk("rnd_rda", da, ref_r[a]);
        chk("rnd_rdb", db, ref_r[b]);
        chk("rnd_cnt", cnt, 32'(m_cnt));
      end else if (sel <= 8) begin
        d = $urandom;
        do_write(a, d);
      end else begin
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        m_clear();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
